// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sum path.
package alu_pkg;

   localparam int XLEN = 32;

   // Status flags produced alongside every sum.
   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
   } alu_flags_t;

endpackage : alu_pkg

// File: rtl/alu_sum_core.sv
// Combinational WIDTH-bit adder with carry-in and status flags.
// The subtract path reuses this block by supplying ~srcB with cin=1.
module alu_sum_core
   import alu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output alu_flags_t       flags
);

   logic [WIDTH:0] full;

   // One extra bit of width captures the unsigned carry-out.
   always_comb begin
      full           = {1'b0, srcA} + {1'b0, srcB} + {{WIDTH{1'b0}}, cin};
      sum            = full[WIDTH-1:0];
      flags.carry    = full[WIDTH];
      // Signed overflow: operands agree in sign but the result does not.
      flags.overflow = (srcA[WIDTH-1] == srcB[WIDTH-1]) &&
                       (full[WIDTH-1] != srcA[WIDTH-1]);
      flags.zero     = (full[WIDTH-1:0] == '0);
      flags.negative = full[WIDTH-1];
   end

endmodule : alu_sum_core

// File: rtl/alu_sum.sv
// Registered sum path: captures the adder result and flags one cycle
// after an accepted input; holds them while idle.
module alu_sum
   import alu_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             cin,
   output logic [WIDTH-1:0] res,
   output logic             out_valid,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   logic [WIDTH-1:0] core_sum;
   alu_flags_t       core_flags;

   logic [WIDTH-1:0] res_d,   res_q;
   alu_flags_t       flags_d, flags_q;
   logic             vld_d,   vld_q;

   alu_sum_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .srcA  (srcA),
      .srcB  (srcB),
      .cin   (cin),
      .sum   (core_sum),
      .flags (core_flags)
   );

   // Next state: take the new sum when accepted, otherwise hold the last one.
   always_comb begin
      res_d   = res_q;
      flags_d = flags_q;
      vld_d   = in_valid;
      if (in_valid) begin
         res_d   = core_sum;
         flags_d = core_flags;
      end
   end

   // Capture registers; reset clears result, flags and valid immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         flags_q <= '0;
         vld_q   <= 1'b0;
      end else begin
         res_q   <= res_d;
         flags_q <= flags_d;
         vld_q   <= vld_d;
      end
   end

   assign res       = res_q;
   assign out_valid = vld_q;
   assign carry     = flags_q.carry;
   assign overflow  = flags_q.overflow;
   assign zero      = flags_q.zero;
   assign negative  = flags_q.negative;

endmodule : alu_sum

// File: tb/tb_alu_sum.sv
// Directed self-checking bench for alu_sum.
module tb_alu_sum;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] srcA, srcB;
   logic         cin;
   logic [W-1:0] res;
   logic         out_valid, carry, overflow, zero, negative;

   int total = 0;
   int bad   = 0;

   logic [W+4:0] obs;

   alu_sum #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .srcA      (srcA),
      .srcB      (srcB),
      .cin       (cin),
      .res       (res),
      .out_valid (out_valid),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero),
      .negative  (negative)
   );

   always #5 clk = ~clk;

   // Observed outputs packed as {out_valid, carry, overflow, zero, negative, res}.
   function automatic logic [W+4:0] snap();
      return {out_valid, carry, overflow, zero, negative, res};
   endfunction

   function automatic logic [W+4:0] ex(input logic v, input logic c, input logic o,
                                       input logic z, input logic n, input logic [W-1:0] r);
      return {v, c, o, z, n, r};
   endfunction

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      in_valid = v;
      srcA     = a;
      srcB     = b;
      cin      = c;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1);
      #2;
      obs = snap(); total++;
      if (obs !== ex(0,0,0,0,0,32'h0)) begin
         bad++; $display("FAIL reset_async got=%h want=%h", obs, ex(0,0,0,0,0,32'h0));
      end
      step(); step();
      obs = snap(); total++;
      if (obs !== ex(0,0,0,0,0,32'h0)) begin
         bad++; $display("FAIL reset_hold got=%h want=%h", obs, ex(0,0,0,0,0,32'h0));
      end
      #2 rst_n = 1'b1;
      drive(1'b1, 32'h0, 32'h0, 1'b0);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,0,0,1,0,32'h0)) begin
         bad++; $display("FAIL first_zero_sum got=%h want=%h", obs, ex(1,0,0,1,0,32'h0));
      end
   endtask

   task automatic test_midcycle();
      drive(1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,0,0,0,0,32'h1)) begin
         bad++; $display("FAIL one_plus_zero got=%h want=%h", obs, ex(1,0,0,0,0,32'h1));
      end
      #1 srcB = 32'h0000_0010;
      #2;
      obs = snap(); total++;
      if (obs !== ex(1,0,0,0,0,32'h1)) begin
         bad++; $display("FAIL midcycle_hidden got=%h want=%h", obs, ex(1,0,0,0,0,32'h1));
      end
      step();
      obs = snap(); total++;
      if (obs !== ex(1,0,0,0,0,32'h11)) begin
         bad++; $display("FAIL midcycle_next_edge got=%h want=%h", obs, ex(1,0,0,0,0,32'h11));
      end
   endtask

   task automatic test_carry();
      drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,1,0,1,0,32'h0)) begin
         bad++; $display("FAIL wrap_carry got=%h want=%h", obs, ex(1,1,0,1,0,32'h0));
      end
      drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,1,0,0,1,32'hFFFF_FFFF)) begin
         bad++; $display("FAIL ones_cin got=%h want=%h", obs, ex(1,1,0,0,1,32'hFFFF_FFFF));
      end
   endtask

   task automatic test_overflow();
      drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,0,1,0,1,32'h8000_0000)) begin
         bad++; $display("FAIL pos_overflow got=%h want=%h", obs, ex(1,0,1,0,1,32'h8000_0000));
      end
      drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,1,1,1,0,32'h0)) begin
         bad++; $display("FAIL neg_overflow_carry got=%h want=%h", obs, ex(1,1,1,1,0,32'h0));
      end
      drive(1'b1, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,0,0,0,1,32'hFFFF_FFFD)) begin
         bad++; $display("FAIL mixed_sign got=%h want=%h", obs, ex(1,0,0,0,1,32'hFFFF_FFFD));
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,0,0,0,0,32'h2345_6789)) begin
         bad++; $display("FAIL b2b_first got=%h want=%h", obs, ex(1,0,0,0,0,32'h2345_6789));
      end
      drive(1'b1, 32'h0000_0005, 32'hFFFF_FFFA, 1'b1);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,1,0,1,0,32'h0)) begin
         bad++; $display("FAIL b2b_second got=%h want=%h", obs, ex(1,1,0,1,0,32'h0));
      end
      drive(1'b1, 32'hC000_0000, 32'hC000_0000, 1'b0);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,1,0,0,1,32'h8000_0000)) begin
         bad++; $display("FAIL b2b_third got=%h want=%h", obs, ex(1,1,0,0,1,32'h8000_0000));
      end
      drive(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b1);
      step();
      obs = snap(); total++;
      if (obs !== ex(0,1,0,0,1,32'h8000_0000)) begin
         bad++; $display("FAIL b2b_idle got=%h want=%h", obs, ex(0,1,0,0,1,32'h8000_0000));
      end
      step();
      obs = snap(); total++;
      if (obs !== ex(0,1,0,0,1,32'h8000_0000)) begin
         bad++; $display("FAIL idle_hold got=%h want=%h", obs, ex(0,1,0,0,1,32'h8000_0000));
      end
   endtask

   task automatic test_reset_midop();
      drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,0,0,0,0,32'h30)) begin
         bad++; $display("FAIL pre_reset_sum got=%h want=%h", obs, ex(1,0,0,0,0,32'h30));
      end
      drive(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      obs = snap(); total++;
      if (obs !== ex(0,0,0,0,0,32'h0)) begin
         bad++; $display("FAIL midop_reset_async got=%h want=%h", obs, ex(0,0,0,0,0,32'h0));
      end
      step();
      obs = snap(); total++;
      if (obs !== ex(0,0,0,0,0,32'h0)) begin
         bad++; $display("FAIL midop_reset_hold got=%h want=%h", obs, ex(0,0,0,0,0,32'h0));
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      step();
      obs = snap(); total++;
      if (obs !== ex(0,0,0,0,0,32'h0)) begin
         bad++; $display("FAIL post_release_idle got=%h want=%h", obs, ex(0,0,0,0,0,32'h0));
      end
      drive(1'b1, 32'h0000_0002, 32'h0000_0003, 1'b1);
      step();
      obs = snap(); total++;
      if (obs !== ex(1,0,0,0,0,32'h6)) begin
         bad++; $display("FAIL post_release_accept got=%h want=%h", obs, ex(1,0,0,0,0,32'h6));
      end
   endtask

   initial begin
      test_reset();
      test_midcycle();
      test_carry();
      test_overflow();
      test_back_to_back();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_alu_sum
